// File: rtl/axi_frame_pkg.sv
// Shared types and constants for the frame read path.
// Holds the control FSM states and AXI encodings.
package axi_frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic int log2_int(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) <= v) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO.
// The head entry is visible on dout whenever the FIFO is not empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_frame_reader.sv
// AXI4 read master fetching one frame in fixed INCR bursts.
// AR issue is credit-paced so the output FIFO never overflows.
module axi_frame_reader
  import axi_frame_pkg::*;
#(
  parameter int C_M_AXI_ID_WIDTH     = 1,
  parameter int C_M_AXI_ADDR_WIDTH   = 32,
  parameter int C_M_AXI_DATA_WIDTH   = 128,
  parameter int C_M_AXI_BURST_LEN    = 16,
  parameter int C_M_AXI_ARUSER_WIDTH = 1,
  parameter int C_M_AXI_RUSER_WIDTH  = 1,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR = 32'h1000_0000,
  parameter int FRAME_BURSTS         = 14400,
  parameter int FIFO_DEPTH           = 64
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            rst,
  input  logic                            frame_start,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            err,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                      M_AXI_ARLEN,
  output logic [2:0]                      M_AXI_ARSIZE,
  output logic [1:0]                      M_AXI_ARBURST,
  output logic                            M_AXI_ARLOCK,
  output logic [3:0]                      M_AXI_ARCACHE,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic [3:0]                      M_AXI_ARQOS,
  output logic [C_M_AXI_ARUSER_WIDTH-1:0] M_AXI_ARUSER,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RLAST,
  input  logic [C_M_AXI_RUSER_WIDTH-1:0]  M_AXI_RUSER,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   out_data,
  output logic                            out_last,
  output logic                            out_valid,
  input  logic                            out_ready
);

  localparam int DW    = C_M_AXI_DATA_WIDTH;
  localparam int BL    = C_M_AXI_BURST_LEN;
  localparam int BB    = DW / 8;
  localparam int TOTAL = FRAME_BURSTS * BL;
  localparam int BSTEP = BL * BB;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  state_e        state;
  logic [31:0]   burst_idx;
  logic [31:0]   beat_cnt;
  logic [31:0]   reserved;
  logic [31:0]   idx_nxt;
  logic [31:0]   res_nxt;
  logic          ar_hs;
  logic          r_hs;
  logic          pop;
  logic          credit_ok;
  logic          burst_end;
  logic          tlast;
  logic          bad_beat;
  logic          drain_ok;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [DW:0]   head;
  logic          unused;

  assign unused = ^{M_AXI_RID, M_AXI_RUSER, fifo_full};

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARLEN   = 8'(BL - 1);
  assign M_AXI_ARSIZE  = 3'(log2_int(BB));
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;
  assign M_AXI_ARUSER  = '0;

  assign M_AXI_RREADY = (state == RUN) | (state == DRAIN);

  assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs  = M_AXI_RVALID & M_AXI_RREADY;
  assign pop   = ~fifo_empty & out_ready;

  assign idx_nxt = burst_idx + (ar_hs ? 32'd1 : 32'd0);
  assign res_nxt = reserved
                 + (ar_hs ? 32'(BL) : 32'd0)
                 - (r_hs ? 32'd1 : 32'd0);

  // A beat in flight moves from reserved into the FIFO, so their sum only grows on AR.
  assign credit_ok = (32'(fifo_count) + reserved
                   + (ar_hs ? 32'(BL) : 32'd0)
                   + 32'(BL)) <= 32'(FIFO_DEPTH);

  assign burst_end = (beat_cnt & 32'(BL - 1)) == 32'(BL - 1);
  assign tlast     = beat_cnt == 32'(TOTAL - 1);
  assign bad_beat  = (M_AXI_RRESP != AXI_RESP_OKAY)
                   | (M_AXI_RLAST != burst_end);

  // Leave DRAIN on the edge that empties the FIFO.
  assign drain_ok = (beat_cnt == 32'(TOTAL))
                  & ((fifo_count == '0)
                   | ((fifo_count == CW'(1)) & pop));

  always_ff @(posedge M_AXI_ACLK) begin
    if (rst) begin
      state         <= IDLE;
      burst_idx     <= '0;
      beat_cnt      <= '0;
      reserved      <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_ARADDR  <= FRAME_BASE_ADDR;
      err           <= 1'b0;
      frame_done    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      reserved   <= res_nxt;
      if (r_hs) begin
        beat_cnt <= beat_cnt + 32'd1;
        if (bad_beat) err <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            state         <= RUN;
            busy          <= 1'b1;
            burst_idx     <= '0;
            beat_cnt      <= '0;
            reserved      <= '0;
            err           <= 1'b0;
            M_AXI_ARVALID <= 1'b1;
            M_AXI_ARADDR  <= FRAME_BASE_ADDR;
          end
        end
        RUN: begin
          burst_idx <= idx_nxt;
          if (!M_AXI_ARVALID || M_AXI_ARREADY) begin
            if ((idx_nxt < 32'(FRAME_BURSTS)) && credit_ok) begin
              M_AXI_ARVALID <= 1'b1;
              M_AXI_ARADDR  <= FRAME_BASE_ADDR
                + C_M_AXI_ADDR_WIDTH'(idx_nxt * 32'(BSTEP));
            end else begin
              M_AXI_ARVALID <= 1'b0;
            end
          end
          if (ar_hs && (idx_nxt == 32'(FRAME_BURSTS))) state <= DRAIN;
        end
        DRAIN: begin
          if (drain_ok) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  sync_fifo_fwft #(
    .WIDTH (DW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (M_AXI_ACLK),
    .rst   (rst),
    .push  (r_hs),
    .pop   (pop),
    .din   ({tlast, M_AXI_RDATA}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_empty ? '0 : head[DW-1:0];
  assign out_last  = ~fifo_empty & head[DW];

endmodule

// File: tb/tb_axi_frame_reader.sv
// Randomized scoreboard bench for axi_frame_reader with a small AXI memory slave.
// Expected beats and AR addresses come from frame-level arithmetic.
module tb_axi_frame_reader;

  localparam int BL    = 16;
  localparam int NB    = 4;
  localparam int DW    = 128;
  localparam int DEPTH = 64;
  localparam int BB    = DW / 8;
  localparam int TOTAL = NB * BL;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          busy;
  logic          frame_done;
  logic          err;
  logic [0:0]    arid;
  logic [31:0]   araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arlock;
  logic [3:0]    arcache;
  logic [2:0]    arprot;
  logic [3:0]    arqos;
  logic [0:0]    aruser;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [0:0]    rid = '0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = 2'b00;
  logic          rlast = 1'b0;
  logic [0:0]    ruser = '0;
  logic          rvalid = 1'b0;
  logic          rready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_valid;
  logic          out_ready = 1'b0;

  always #5 clk = ~clk;

  axi_frame_reader #(
    .C_M_AXI_BURST_LEN (BL),
    .FRAME_BURSTS      (NB),
    .FIFO_DEPTH        (DEPTH)
  ) dut (
    .M_AXI_ACLK    (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .busy          (busy),
    .frame_done    (frame_done),
    .err           (err),
    .M_AXI_ARID    (arid),
    .M_AXI_ARADDR  (araddr),
    .M_AXI_ARLEN   (arlen),
    .M_AXI_ARSIZE  (arsize),
    .M_AXI_ARBURST (arburst),
    .M_AXI_ARLOCK  (arlock),
    .M_AXI_ARCACHE (arcache),
    .M_AXI_ARPROT  (arprot),
    .M_AXI_ARQOS   (arqos),
    .M_AXI_ARUSER  (aruser),
    .M_AXI_ARVALID (arvalid),
    .M_AXI_ARREADY (arready),
    .M_AXI_RID     (rid),
    .M_AXI_RDATA   (rdata),
    .M_AXI_RRESP   (rresp),
    .M_AXI_RLAST   (rlast),
    .M_AXI_RUSER   (ruser),
    .M_AXI_RVALID  (rvalid),
    .M_AXI_RREADY  (rready),
    .out_data      (out_data),
    .out_last      (out_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  int checks = 0;
  int errors = 0;

  int ar_prob = 100;
  int rv_prob = 100;
  int or_prob = 100;
  int ar_stall = 0;
  int inj_rresp = -1;
  int inj_rlast = -1;
  logic [31:0] seed = '0;

  logic [DW:0] exp_q[$];
  logic [31:0] exp_ar[$];
  bit          exp_err = 1'b0;

  int ar_cnt = 0;
  int out_beats = 0;
  int done_pulses = 0;
  int stall_cycles = 0;
  int overflow = 0;
  int done_chk = 0;
  bit prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic chk(input bit ok, input string name,
                     input logic [131:0] act, input logic [131:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic bit chance(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  // Frame beat i carries the four 32-bit words seed+4i .. seed+4i+3.
  function automatic logic [DW:0] model_beat(input int i);
    logic [31:0] w;
    w = seed + 32'(4 * i);
    return {i == TOTAL - 1, w + 32'd3, w + 32'd2, w + 32'd1, w};
  endfunction

  function automatic logic [DW-1:0] mem_at(input logic [31:0] a);
    logic [31:0] k;
    k = seed + ((a - BASE) >> 2);
    return {k + 32'd3, k + 32'd2, k + 32'd1, k};
  endfunction

  logic [31:0] aq[$];
  int sb = 0;
  int sbeats = 0;
  bit hs;
  bit rst_s;

  always @(posedge clk) begin
    rst_s = rst;
    hs = rvalid && rready;
    if (rst_s) begin
      aq.delete();
      sb = 0;
      sbeats = 0;
    end else begin
      if (arvalid && arready) aq.push_back(araddr);
      if (hs) begin
        sb++;
        sbeats++;
        if (sb == BL) begin
          sb = 0;
          void'(aq.pop_front());
        end
      end
    end
    #2;
    if (rst_s) begin
      rvalid = 1'b0;
      arready = 1'b0;
    end else begin
      if (!(rvalid && !hs)) begin
        if (aq.size() > 0 && chance(rv_prob)) begin
          rvalid = 1'b1;
          rdata = mem_at(aq[0] + 32'(sb * BB));
          rlast = (sb == BL - 1) || (sbeats == inj_rlast);
          rresp = (sbeats == inj_rresp) ? 2'b10 : 2'b00;
        end else begin
          rvalid = 1'b0;
        end
      end
      if (ar_stall > 0) begin
        arready = 1'b0;
        ar_stall--;
      end else begin
        arready = chance(ar_prob);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = chance(or_prob);
  end

  always @(negedge clk) begin
    logic [DW:0] e;
    logic [31:0] a;
    if (rst) begin
      prev_stall = 1'b0;
      done_chk = 0;
    end else begin
      if (frame_done) done_pulses++;
      if (done_chk == 1) begin
        chk(frame_done && busy, "done_pulse", {frame_done, busy}, 2'b11);
        chk(err == exp_err, "err_flag", err, exp_err);
        done_chk = 2;
      end else if (done_chk == 2) begin
        chk(!frame_done && !busy, "done_fall", {frame_done, busy}, 2'b00);
        done_chk = 0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_beat", {out_last, out_data}, 0);
        end else begin
          e = exp_q.pop_front();
          chk({out_last, out_data} == e, "beat", {out_last, out_data}, e);
          if (e[DW]) done_chk = 1;
        end
        out_beats++;
      end
      if (arvalid && arready) begin
        ar_cnt++;
        if (exp_ar.size() == 0) begin
          chk(1'b0, "unexpected_ar", araddr, 0);
        end else begin
          a = exp_ar.pop_front();
          chk(araddr == a && arlen == 8'd15 && arsize == 3'd4
              && arburst == 2'b01 && arcache == 4'b0011
              && arid == 1'b0 && !arlock,
              "ar_fields", {araddr, arlen, arsize}, {a, 8'd15, 3'd4});
        end
      end
      if (prev_stall) begin
        chk(arvalid && araddr == prev_addr, "ar_hold",
            {arvalid, araddr}, {1'b1, prev_addr});
        stall_cycles++;
      end
      prev_stall = arvalid && !arready;
      prev_addr = araddr;
      if (dut.u_fifo.full && rvalid && rready) overflow++;
    end
  end

  task automatic start_frame(input bit exp_e);
    seed = $urandom;
    exp_err = exp_e;
    sbeats = 0;
    ar_cnt = 0;
    out_beats = 0;
    stall_cycles = 0;
    for (int i = 0; i < TOTAL; i++) exp_q.push_back(model_beat(i));
    for (int b = 0; b < NB; b++) exp_ar.push_back(BASE + 32'(b * BL * BB));
    @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    @(negedge clk);
    chk(busy && arvalid, "start_busy_arvalid", {busy, arvalid}, 2'b11);
    chk(!err, "err_cleared", err, 0);
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_pulses;
    for (int i = 0; i < budget && done_pulses == d0; i++) @(negedge clk);
    chk(done_pulses != d0, "done_timeout", done_pulses - d0, 1);
    repeat (3) @(negedge clk);
    chk(exp_q.size() == 0, "beats_left", exp_q.size(), 0);
    chk(ar_cnt == NB, "ar_count", ar_cnt, NB);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(!arvalid && !rready && !out_valid && !out_last,
        "reset_axi", {arvalid, rready, out_valid, out_last}, 0);
    chk(!busy && !frame_done && !err, "reset_ctl",
        {busy, frame_done, err}, 0);
    chk(araddr == BASE && out_data == '0, "reset_addr_data",
        {araddr, out_data}, {BASE, 128'd0});
    @(posedge clk);
    #1 rst = 1'b0;

    start_frame(1'b0);
    wait_done(2000);

    for (int f = 0; f < 3; f++) begin
      ar_prob = 30 + int'($urandom_range(70));
      rv_prob = 30 + int'($urandom_range(70));
      or_prob = 30 + int'($urandom_range(70));
      start_frame(1'b0);
      wait_done(5000);
    end
    ar_prob = 100;
    rv_prob = 100;
    or_prob = 100;

    or_prob = 0;
    start_frame(1'b0);
    repeat (200) @(negedge clk);
    chk(ar_cnt == NB, "bp_ar_count", ar_cnt, NB);
    chk(dut.u_fifo.count == 7'd64, "bp_fifo_full", dut.u_fifo.count, 64);
    chk(out_valid && out_beats == 0, "bp_hold", {out_valid, out_beats}, 1);
    or_prob = 100;
    wait_done(2000);

    ar_stall = 14;
    start_frame(1'b0);
    wait_done(2000);
    chk(stall_cycles >= 10, "ar_stall_cycles", stall_cycles, 10);

    inj_rresp = 5;
    start_frame(1'b1);
    wait_done(2000);
    inj_rresp = -1;

    inj_rlast = 7;
    start_frame(1'b1);
    wait_done(2000);
    inj_rlast = -1;

    start_frame(1'b0);
    wait_done(2000);

    rv_prob = 60;
    start_frame(1'b0);
    n = 0;
    while (out_beats < 20 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(out_beats >= 20, "pre_reset_beats", out_beats, 20);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    exp_ar.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(!arvalid && !busy && !out_valid, "mid_reset",
        {arvalid, busy, out_valid}, 0);
    rv_prob = 100;
    repeat (3) @(negedge clk);
    start_frame(1'b0);
    wait_done(2000);

    d0 = done_pulses;
    start_frame(1'b0);
    repeat (5) @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    wait_done(2000);
    repeat (50) @(negedge clk);
    chk(ar_cnt == NB, "repulse_ar_count", ar_cnt, NB);
    chk(done_pulses - d0 == 1, "repulse_done", done_pulses - d0, 1);

    chk(overflow == 0, "fifo_overflow", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
